// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: sweeps every input vector of a combinational gate under
// test in binary order, waits a programmable settle time per vector, checks
// the gate output against the expected reduction function, and reports the
// mismatch count, the first failing vector and a pass flag.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for START; results of the last sweep held
// S_SETTLE | VEC applied, counting SETTLE cycles before the check
// S_CHECK  | one cycle; Q compared with FUNC(VEC) at the closing edge
// S_FIN    | one cycle; DONE high, PASS computed from the final ERR_CNT
module gate_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int FUNC   = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            ABORT,
    input  logic            Q,
    output logic [N_IN-1:0] VEC,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [N_IN:0]   ERR_CNT,
    output logic [N_IN-1:0] FIRST_FAIL
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_FIN
    } state_t;

    // With SETTLE=0 the settle phase is skipped and each vector goes
    // straight to its check cycle.
    localparam state_t   VEC_STATE   = (SETTLE == 0) ? S_CHECK : S_SETTLE;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       fail_flag;
    logic       expected_q;
    logic       mismatch;
    logic       last_vec;

    // Expected gate output for the vector currently applied.
    always_comb begin
        expected_q = &VEC;
        if (FUNC == 1) begin
            expected_q = |VEC;
        end else if (FUNC == 2) begin
            expected_q = ^VEC;
        end else if (FUNC == 3) begin
            expected_q = ~&VEC;
        end
        mismatch = (Q != expected_q);
        last_vec = &VEC;
    end

    // Sweep sequencer with registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            fail_flag  <= 1'b0;
            VEC        <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FIRST_FAIL <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state      <= VEC_STATE;
                        VEC        <= '0;
                        ERR_CNT    <= '0;
                        FIRST_FAIL <= '0;
                        PASS       <= 1'b0;
                        fail_flag  <= 1'b0;
                        settle_cnt <= '0;
                        BUSY       <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (ABORT) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                        VEC   <= '0;
                        PASS  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    // An abort discards this cycle's comparison entirely.
                    if (ABORT) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                        VEC   <= '0;
                        PASS  <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            ERR_CNT <= ERR_CNT + 1'b1;
                            if (!fail_flag) begin
                                FIRST_FAIL <= VEC;
                                fail_flag  <= 1'b1;
                            end
                        end
                        if (last_vec) begin
                            state <= S_FIN;
                            BUSY  <= 1'b0;
                            VEC   <= '0;
                            DONE  <= 1'b1;
                        end else begin
                            VEC        <= VEC + 1'b1;
                            settle_cnt <= '0;
                            state      <= VEC_STATE;
                        end
                    end
                end
                S_FIN: begin
                    PASS  <= (ERR_CNT == '0);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Sequencing controller for a combinational logic gate under test (and1 and its sibling gates).
- On START, drives every input vector to the gate in binary order. After a programmable settle time, samples the gate output Q and compares it with the expected function.
- Accumulates mismatch count and first failing vector; reports PASS/DONE. Used as self-checking wrapper around gate instances in Proyecto_2 benches and on-board demos.

Parameters:
- N_IN, 2, number of gate inputs (1..8); VEC width.
- SETTLE, 1, wait cycles after applying a vector before the check cycle (0..15).
- FUNC, 0, expected function, reduction over VEC: 0 AND, 1 OR, 2 XOR, 3 NAND; any other value treated as AND.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  sweep request, sampled only in IDLE.
- ABORT  in  1  cancel sweep in progress.
- Q  in  1  output of gate under test.
- VEC  out  N_IN  gate inputs; bit0 = A, bit1 = B, ...
- BUSY  out  1  high while sweeping.
- DONE  out  1  one-cycle pulse at sweep completion.
- PASS  out  1  high if last completed sweep had zero mismatches.
- ERR_CNT  out  N_IN+1  mismatch count, max 2^N_IN.
- FIRST_FAIL  out  N_IN  VEC of first mismatch; 0 if none.

Behaviour:
- Interface: one clock domain, CLK; reset RST is synchronous and active-high. All outputs registered.
- Reset: state IDLE; VEC, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL all 0; settle counter 0. RST overrides every other input at any time, including mid-sweep.
- States: IDLE, SETTLE, CHECK, FIN.
- IDLE:
  - START=1 at an edge: next state SETTLE (or CHECK if SETTLE=0).
  - Same edge: VEC<=0, ERR_CNT<=0, FIRST_FAIL<=0, PASS<=0, fail flag cleared, settle counter<=0, BUSY<=1.
  - ABORT is ignored in IDLE.
- SETTLE: VEC held. Counter increments each cycle. After SETTLE cycles, goes to CHECK.
- CHECK (one cycle, VEC held):
  - Q is sampled at the closing edge. Mismatch occurs when Q != FUNC(VEC).
  - On mismatch: ERR_CNT+1; if the fail flag was clear, FIRST_FAIL<=VEC and the flag is set.
  - If VEC = all ones: next state FIN, BUSY<=0, VEC<=0.
  - Otherwise: VEC<=VEC+1, counter<=0, next state SETTLE (or CHECK if SETTLE=0).
- Vector timing: each vector is held SETTLE+1 cycles. BUSY is high for exactly 2^N_IN*(SETTLE+1) cycles.
- FIN (one cycle): DONE=1. PASS<=(ERR_CNT==0), including any mismatch from the final CHECK. Next state IDLE. START is ignored in FIN.
- Results: ERR_CNT, FIRST_FAIL and PASS hold until the next accepted START or RST.
- START while BUSY: ignored; no restart or queueing.
- ABORT in SETTLE/CHECK:
  - Next edge: IDLE, BUSY<=0, VEC<=0, PASS<=0, no DONE.
  - ERR_CNT and FIRST_FAIL keep partial values.
  - ABORT wins over a final-vector CHECK in the same cycle. The mismatch in that aborted CHECK is not counted.
- ERR_CNT cannot overflow: width N_IN+1 holds 2^N_IN.

Test Plan:
1. Reset: RST=1 for 2 cycles with START=1 -> all outputs 0, no sweep starts; release RST, START=0 -> BUSY stays 0.
2. N_IN=2, SETTLE=1, FUNC=0, Q from a correct and1:
   - START pulse at edge E0 -> BUSY=1 for 8 cycles after E0.
   - VEC sequence 00,00,01,01,10,10,11,11.
   - DONE pulse on 9th cycle, then ERR_CNT=0, PASS=1, FIRST_FAIL=0.
3. Same config, Q = A|B (faulty gate) -> ERR_CNT=2, FIRST_FAIL=01, PASS=0, DONE pulses once.
4. Same config, Q stuck at 0 -> ERR_CNT=1, FIRST_FAIL=11, PASS=0. Holding START high through the sweep causes no restart; a new sweep begins only after DONE+IDLE.
5. ABORT asserted while VEC=10 -> BUSY=0 and VEC=00 next cycle, no DONE, PASS=0. A subsequent START with a correct gate yields ERR_CNT=0, PASS=1.
6. N_IN=3, SETTLE=0, FUNC=2, correct XOR model -> VEC 000..111, one per cycle, BUSY 8 cycles, PASS=1. RST asserted at VEC=011 -> all outputs 0 next edge.
